// File: rtl/regfile_pkg.sv
// Shared state encoding, default sizes and clog2 helper for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NR    = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read path: Ready gating, address-0 zero mux and, with REGFILE_BYPASS_EN,
// same-cycle write-to-read bypass (port 1 wins over port 0).
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]    ra,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             ready,
`ifdef REGFILE_BYPASS_EN
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [WIDTH-1:0] wd1,
`endif
    output logic [WIDTH-1:0] rdata
);

    always_comb begin
        rdata = mem_data;
`ifdef REGFILE_BYPASS_EN
        if (we1 && wa1 == ra)
            rdata = wd1;
        else if (we0 && wa0 == ra)
            rdata = wd0;
`endif
        // Ready gating and the hardwired zero entry override everything else.
        if (!ready || ra == '0)
            rdata = '0;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NR read ports, two write ports, post-reset scrub,
// registered write-conflict flag. Optional bypass under REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int NR    = DEF_NR,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [NR*AW-1:0]    RA,
    output logic [NR*WIDTH-1:0] BusR,
    input  logic                RegWr0,
    input  logic [AW-1:0]       RW0,
    input  logic [WIDTH-1:0]    BusW0,
    input  logic                RegWr1,
    input  logic [AW-1:0]       RW1,
    input  logic [WIDTH-1:0]    BusW1,
    output logic                Ready,
    output logic                WrConflict
);

    state_t           state, state_nx;
    logic [AW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             ready;
    logic             wr0, wr1;

    assign ready = (state == ST_READY);
    assign Ready = ready;
    assign wr0   = ready && RegWr0 && (RW0 != '0);
    assign wr1   = ready && RegWr1 && (RW1 != '0);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == ST_CLEAR) begin
            cnt_nx = cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1))
                state_nx = ST_READY;
        end
    end

    // Array has no reset; a low Reset_n edge leaves it untouched and the scrub clears it.
    always_ff @(posedge Clk) begin
        if (Reset_n) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= '0;
            end else begin
                if (wr0) mem[RW0] <= BusW0;
                if (wr1) mem[RW1] <= BusW1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            WrConflict <= 1'b0;
        else
            WrConflict <= wr0 && wr1 && (RW0 == RW1);
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra_i;
        assign ra_i = RA[i*AW +: AW];

        regfile_rdport #(
            .WIDTH(WIDTH),
            .AW   (AW)
        ) u_rdport (
            .ra      (ra_i),
            .mem_data(mem[ra_i]),
            .ready   (ready),
`ifdef REGFILE_BYPASS_EN
            .we0     (RegWr0),
            .wa0     (RW0),
            .wd0     (BusW0),
            .we1     (RegWr1),
            .wa1     (RW1),
            .wd1     (BusW1),
`endif
            .rdata   (BusR[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scrub/write/conflict/reset cases plus
// random traffic against an array model; follows REGFILE_BYPASS_EN when defined.
module tb_regfile_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NR    = 2;
    localparam int AW    = 5;

    logic                Clk = 1'b0;
    logic                Reset_n = 1'b0;
    logic [NR*AW-1:0]    RA = '0;
    logic [NR*WIDTH-1:0] BusR;
    logic                RegWr0 = 1'b0;
    logic [AW-1:0]       RW0 = '0;
    logic [WIDTH-1:0]    BusW0 = '0;
    logic                RegWr1 = 1'b0;
    logic [AW-1:0]       RW1 = '0;
    logic [WIDTH-1:0]    BusW1 = '0;
    logic                Ready;
    logic                WrConflict;

    always #5 Clk = ~Clk;

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .RA        (RA),
        .BusR      (BusR),
        .RegWr0    (RegWr0),
        .RW0       (RW0),
        .BusW0     (BusW0),
        .RegWr1    (RegWr1),
        .RW1       (RW1),
        .BusW1     (BusW1),
        .Ready     (Ready),
        .WrConflict(WrConflict)
    );

    int checks   = 0;
    int failures = 0;

    // Model: contents, edges since reset release, expected conflict flag.
    logic [WIDTH-1:0] model [DEPTH];
    int  rel_edges = 0;
    bit  m_conf    = 1'b0;
    bit  valid     = 1'b0;

    function automatic bit m_ready();
        return rel_edges >= DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] a);
        if (!m_ready() || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (RegWr1 && RW1 == a) return BusW1;
        if (RegWr0 && RW0 == a) return BusW0;
`endif
        return model[a];
    endfunction

    // One clock: check outputs at negedge, then advance the model at the rising edge.
    task automatic cyc();
        @(negedge Clk);
        if (valid) begin
            for (int p = 0; p < NR; p++)
                chk($sformatf("rd%0d", p), 64'(BusR[p*WIDTH +: WIDTH]), 64'(exp_rd(RA[p*AW +: AW])));
            chk("ready", 64'(Ready), 64'(m_ready()));
            chk("conflict", 64'(WrConflict), 64'(m_conf));
        end
        @(posedge Clk);
        if (!Reset_n) begin
            rel_edges = 0;
            m_conf    = 1'b0;
            valid     = 1'b1;
        end else if (valid) begin
            if (m_ready()) begin
                if (RegWr0 && RW0 != '0) model[RW0] = BusW0;
                if (RegWr1 && RW1 != '0) model[RW1] = BusW1;
                m_conf = RegWr0 && RegWr1 && RW0 == RW1 && RW0 != '0;
            end else begin
                m_conf = 1'b0;
                rel_edges++;
                // Scrub is invisible until Ready; treat it as clearing everything at once.
                if (rel_edges == DEPTH)
                    for (int i = 0; i < DEPTH; i++) model[i] = '0;
            end
        end
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 40) begin
            cyc();
            n++;
            if (Ready === 1'b1) break;
        end
    endtask

    task automatic idle();
        RegWr0 = 1'b0;
        RegWr1 = 1'b0;
    endtask

    int n;

    initial begin
        // Reset low for two cycles, then release and count scrub edges.
        cyc();
        cyc();
        Reset_n = 1'b1;
        wait_ready(n);
        chk("scrub_len", 64'(n), 64'(32));

        // Every entry reads zero after scrub.
        for (int a = 1; a < DEPTH; a += NR) begin
            for (int p = 0; p < NR; p++) RA[p*AW +: AW] = AW'(a + p);
            cyc();
        end

        // Basic write/read.
        RA[0 +: AW] = AW'(5);
        RegWr0 = 1'b1; RW0 = AW'(5); BusW0 = 32'hDEADBEEF;
        cyc();
        idle();
        #1 chk("basic_rd", 64'(BusR[0 +: WIDTH]), 64'h0000_0000_DEAD_BEEF);
        cyc();

        // Write to register 0 is discarded and raises no conflict.
        RA = '0;
        RegWr1 = 1'b1; RW1 = '0; BusW1 = 32'hFFFFFFFF;
        cyc();
        idle();
        #1 chk("r0_rd0", 64'(BusR[0 +: WIDTH]), 64'h0);
        chk("r0_rd1", 64'(BusR[WIDTH +: WIDTH]), 64'h0);
        chk("r0_conf", 64'(WrConflict), 64'h0);
        cyc();

        // Dual write to the same register: port 1 wins, one-cycle conflict pulse.
        RA[0 +: AW] = AW'(7);
        RegWr0 = 1'b1; RW0 = AW'(7); BusW0 = 32'h11;
        RegWr1 = 1'b1; RW1 = AW'(7); BusW1 = 32'h22;
        cyc();
        idle();
        #1 chk("conf_data", 64'(BusR[0 +: WIDTH]), 64'h22);
        chk("conf_hi", 64'(WrConflict), 64'h1);
        cyc();
        chk("conf_lo", 64'(WrConflict), 64'h0);

        // Bypass: same-cycle read of a write in flight.
        RA[WIDTH/WIDTH*AW +: AW] = AW'(3);
        RegWr0 = 1'b1; RW0 = AW'(3); BusW0 = 32'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass", 64'(BusR[WIDTH +: WIDTH]), 64'h1234);
`else
        chk("no_bypass", 64'(BusR[WIDTH +: WIDTH]), 64'h0);
`endif
        cyc();
        idle();

        // Reset mid-operation and mid-scrub; writes during scrub are ignored.
        RegWr0 = 1'b1; RW0 = AW'(9); BusW0 = 32'hA5;
        cyc();
        idle();
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            RegWr0 = 1'b1; RW0 = AW'($urandom_range(1, DEPTH - 1)); BusW0 = $urandom;
            RegWr1 = 1'b1; RW1 = AW'(9); BusW1 = $urandom;
            cyc();
        end
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        RegWr0 = 1'b1; RW0 = AW'(9); BusW0 = 32'h5A5A;
        wait_ready(n);
        idle();
        chk("rescrub_len", 64'(n), 64'(32));
        RA[0 +: AW] = AW'(9);
        #1 chk("r9_cleared", 64'(BusR[0 +: WIDTH]), 64'h0);
        cyc();

        // Random traffic with frequent address collisions.
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < NR; p++) RA[p*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
            RegWr0 = 1'($urandom_range(0, 1));
            RegWr1 = 1'($urandom_range(0, 1));
            RW0    = AW'($urandom_range(0, 7));
            RW1    = ($urandom_range(0, 3) == 0) ? RW0 : AW'($urandom_range(0, 7));
            BusW0  = $urandom;
            BusW1  = $urandom;
            cyc();
        end
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
